// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned addr_w = 32;
  localparam int unsigned data_w = 32;
  localparam int unsigned strb_w = 4;

  // Request bus towards memory (also the requester-side request format)
  typedef struct packed {
    logic              mem_valid;
    logic              mem_fence;
    logic              mem_instr;
    logic [addr_w-1:0] mem_addr;
    logic [data_w-1:0] mem_wdata;
    logic [strb_w-1:0] mem_wstrb;
  } mem_in_type;

  // Response bus from memory (also the requester-side response format)
  typedef struct packed {
    logic              mem_ready;
    logic [data_w-1:0] mem_rdata;
  } mem_out_type;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_type;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_type;

  // Arbiter control state; slot contents live in the arb_slot instances
  typedef struct packed {
    arb_state_type state;
    grant_type     last_grant;
  } reg_type;

  localparam reg_type reg_init = '{state: IDLE, last_grant: GRANT_I};

  // Build the memory-side request for the granted side
  function automatic mem_in_type map_issue(input mem_in_type req, input logic is_data);
    mem_in_type o;
    o           = req;
    o.mem_valid = 1'b1;
    if (is_data) begin
      o.mem_instr = 1'b0;
    end else begin
      o.mem_instr = 1'b1;
      o.mem_fence = 1'b0;
      o.mem_wstrb = '0;
    end
    return o;
  endfunction

endpackage

// File: rtl/mem_arbiter_slot.sv
// One-entry capture register holding a request that could not issue at once.
module arb_slot
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       clear,
  input  mem_in_type din,
  output logic       valid,
  output mem_in_type dout
);

  // Load has priority; load and clear are never raised together by the arbiter
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (clear) begin
      valid <= 1'b0;
      dout  <= '0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Merges instruction-fetch and data requests onto one shared memory port.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit arb_mode = 1'b1,
  parameter bit bypass   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  input  mem_out_type mem_out,
  output mem_in_type  mem_in
);

  reg_type    r;
  reg_type    rin;

  logic       i_slot_valid;
  logic       d_slot_valid;
  mem_in_type i_slot_q;
  mem_in_type d_slot_q;
  logic       i_load;
  logic       i_clear;
  logic       d_load;
  logic       d_clear;

  logic       busy_i;
  logic       busy_d;
  logic       done;
  logic       can_issue;
  logic       i_viol;
  logic       d_viol;
  logic       i_ok;
  logic       d_ok;
  logic       i_cand;
  logic       d_cand;
  logic       pick_i;
  logic       pick_d;
  logic       issue;
  mem_in_type issue_req;

  arb_slot u_slot_i (
    .clk   (clk),
    .rst   (rst),
    .load  (i_load),
    .clear (i_clear),
    .din   (imem_in),
    .valid (i_slot_valid),
    .dout  (i_slot_q)
  );

  arb_slot u_slot_d (
    .clk   (clk),
    .rst   (rst),
    .load  (d_load),
    .clear (d_clear),
    .din   (dmem_in),
    .valid (d_slot_valid),
    .dout  (d_slot_q)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r <= reg_init;
    end else begin
      r <= rin;
    end
  end

  // Next state: candidate selection, issue, slot load/clear
  always_comb begin
    rin       = r;
    i_load    = 1'b0;
    i_clear   = 1'b0;
    d_load    = 1'b0;
    d_clear   = 1'b0;
    issue     = 1'b0;
    issue_req = '0;

    busy_i    = (r.state == BUSY_I);
    busy_d    = (r.state == BUSY_D);
    done      = (busy_i | busy_d) & mem_out.mem_ready;
    can_issue = (r.state == IDLE) | done;

    // A side may re-request in the cycle its ready is returned, not before
    i_viol = imem_in.mem_valid & (i_slot_valid | (busy_i & ~mem_out.mem_ready));
    d_viol = dmem_in.mem_valid & (d_slot_valid | (busy_d & ~mem_out.mem_ready));
    i_ok   = imem_in.mem_valid & ~i_viol;
    d_ok   = dmem_in.mem_valid & ~d_viol;

    i_cand = i_slot_valid | (bypass & i_ok);
    d_cand = d_slot_valid | (bypass & d_ok);

    // Data wins a tie in fixed mode; round-robin hands it to the side not granted last
    pick_d = d_cand & (~i_cand | (arb_mode ? (r.last_grant == GRANT_I) : 1'b1));
    pick_i = i_cand & ~pick_d;

    if (done) begin
      rin.state = IDLE;
    end

    if (can_issue && pick_i) begin
      issue          = 1'b1;
      issue_req      = map_issue(i_slot_valid ? i_slot_q : imem_in, 1'b0);
      i_clear        = i_slot_valid;
      rin.state      = BUSY_I;
      rin.last_grant = GRANT_I;
    end else if (can_issue && pick_d) begin
      issue          = 1'b1;
      issue_req      = map_issue(d_slot_valid ? d_slot_q : dmem_in, 1'b1);
      d_clear        = d_slot_valid;
      rin.state      = BUSY_D;
      rin.last_grant = GRANT_D;
    end

    // Accepted arrivals that did not go straight out are parked in their slot
    i_load = i_ok & ~(can_issue & pick_i & ~i_slot_valid);
    d_load = d_ok & ~(can_issue & pick_d & ~d_slot_valid);
  end

  // Outputs: issue pulse to memory and ready/rdata routed to the granted side only
  always_comb begin
    mem_in   = '0;
    imem_out = '0;
    dmem_out = '0;
    if (!rst) begin
      if (issue) begin
        mem_in = issue_req;
      end
      if (busy_i && mem_out.mem_ready) begin
        imem_out.mem_ready = 1'b1;
        imem_out.mem_rdata = mem_out.mem_rdata;
      end
      if (busy_d && mem_out.mem_ready) begin
        dmem_out.mem_ready = 1'b1;
        dmem_out.mem_rdata = mem_out.mem_rdata;
      end
    end
  end

  // Requester overrun: the new request is dropped, the old entry kept
  a_no_i_overrun: assert property (@(posedge clk) disable iff (rst) !i_viol);
  a_no_d_overrun: assert property (@(posedge clk) disable iff (rst) !d_viol);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic        rst_fp;
  mem_in_type  imem_in;
  mem_in_type  dmem_in;
  mem_out_type mem_out;
  mem_out_type imem_out;
  mem_out_type dmem_out;
  mem_in_type  mem_in;
  mem_out_type imem_out_fp;
  mem_out_type dmem_out_fp;
  mem_in_type  mem_in_fp;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.arb_mode(1'b1), .bypass(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .imem_in  (imem_in),
    .imem_out (imem_out),
    .dmem_in  (dmem_in),
    .dmem_out (dmem_out),
    .mem_out  (mem_out),
    .mem_in   (mem_in)
  );

  mem_arbiter #(.arb_mode(1'b0), .bypass(1'b1)) dut_fp (
    .clk      (clk),
    .rst      (rst_fp),
    .imem_in  (imem_in),
    .imem_out (imem_out_fp),
    .dmem_in  (dmem_in),
    .dmem_out (dmem_out_fp),
    .mem_out  (mem_out),
    .mem_in   (mem_in_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; pulses last exactly one cycle
  task automatic next_cycle();
    @(posedge clk);
    #1;
    imem_in = '0;
    dmem_in = '0;
    mem_out = '0;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic req_i(input logic [31:0] addr);
    imem_in.mem_valid = 1'b1;
    imem_in.mem_addr  = addr;
  endtask

  task automatic req_d(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic fence);
    dmem_in.mem_valid = 1'b1;
    dmem_in.mem_addr  = addr;
    dmem_in.mem_wdata = wdata;
    dmem_in.mem_wstrb = wstrb;
    dmem_in.mem_fence = fence;
  endtask

  task automatic mem_ack(input logic [31:0] rdata);
    mem_out.mem_ready = 1'b1;
    mem_out.mem_rdata = rdata;
  endtask

  task automatic apply_reset();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    rst_fp  = 1'b1;
    imem_in = '0;
    dmem_in = '0;
    mem_out = '0;

    // Reset and idle
    next_cycle();
    settle();
    check("rst_mem_in", 32'(mem_in), 32'd0);
    check("rst_iready", 32'(imem_out.mem_ready), 32'd0);
    check("rst_dready", 32'(dmem_out.mem_ready), 32'd0);
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      settle();
      check("idle_valid", 32'(mem_in.mem_valid), 32'd0);
      check("idle_iready", 32'(imem_out.mem_ready), 32'd0);
      check("idle_dready", 32'(dmem_out.mem_ready), 32'd0);
    end

    // Single bypassed store, memory ready 3 cycles later
    next_cycle();
    req_d(32'h100, 32'hDEADBEEF, 4'hF, 1'b0);
    settle();
    check("st_valid", 32'(mem_in.mem_valid), 32'd1);
    check("st_addr", mem_in.mem_addr, 32'h100);
    check("st_wdata", mem_in.mem_wdata, 32'hDEADBEEF);
    check("st_wstrb", 32'(mem_in.mem_wstrb), 32'hF);
    check("st_instr", 32'(mem_in.mem_instr), 32'd0);
    for (int i = 1; i < 3; i++) begin
      next_cycle();
      settle();
      check("st_wait_valid", 32'(mem_in.mem_valid), 32'd0);
      check("st_wait_dready", 32'(dmem_out.mem_ready), 32'd0);
    end
    next_cycle();
    mem_ack(32'h12345678);
    settle();
    check("st_dready", 32'(dmem_out.mem_ready), 32'd1);
    check("st_drdata", dmem_out.mem_rdata, 32'h12345678);
    check("st_iready", 32'(imem_out.mem_ready), 32'd0);
    check("st_irdata", imem_out.mem_rdata, 32'd0);
    next_cycle();
    settle();
    check("st_after_dready", 32'(dmem_out.mem_ready), 32'd0);

    // Simultaneous requests after reset (last grant = instr): data first
    apply_reset();
    next_cycle();
    req_i(32'h0);
    req_d(32'h200, 32'h0, 4'h0, 1'b0);
    settle();
    check("sim_valid0", 32'(mem_in.mem_valid), 32'd1);
    check("sim_addr0", mem_in.mem_addr, 32'h200);
    check("sim_instr0", 32'(mem_in.mem_instr), 32'd0);
    next_cycle();
    mem_ack(32'hAAAA0001);
    settle();
    check("sim_dready", 32'(dmem_out.mem_ready), 32'd1);
    check("sim_drdata", dmem_out.mem_rdata, 32'hAAAA0001);
    check("sim_iready0", 32'(imem_out.mem_ready), 32'd0);
    check("sim_valid1", 32'(mem_in.mem_valid), 32'd1);
    check("sim_addr1", mem_in.mem_addr, 32'h0);
    check("sim_instr1", 32'(mem_in.mem_instr), 32'd1);
    next_cycle();
    mem_ack(32'hBBBB0002);
    settle();
    check("sim_iready", 32'(imem_out.mem_ready), 32'd1);
    check("sim_irdata", imem_out.mem_rdata, 32'hBBBB0002);
    check("sim_dready1", 32'(dmem_out.mem_ready), 32'd0);
    check("sim_valid2", 32'(mem_in.mem_valid), 32'd0);

    // Fence arriving during a fetch is latched and issued on fetch ready
    next_cycle();
    req_i(32'h40);
    settle();
    check("fn_fetch_instr", 32'(mem_in.mem_instr), 32'd1);
    next_cycle();
    req_d(32'h0, 32'h0, 4'h0, 1'b1);
    settle();
    check("fn_latched_valid", 32'(mem_in.mem_valid), 32'd0);
    next_cycle();
    mem_ack(32'h00C0FFEE);
    settle();
    check("fn_iready", 32'(imem_out.mem_ready), 32'd1);
    check("fn_valid", 32'(mem_in.mem_valid), 32'd1);
    check("fn_fence", 32'(mem_in.mem_fence), 32'd1);
    check("fn_wstrb", 32'(mem_in.mem_wstrb), 32'd0);
    check("fn_instr", 32'(mem_in.mem_instr), 32'd0);
    next_cycle();
    mem_ack(32'h0000F00D);
    settle();
    check("fn_dready", 32'(dmem_out.mem_ready), 32'd1);
    check("fn_drdata", dmem_out.mem_rdata, 32'h0000F00D);
    check("fn_iready1", 32'(imem_out.mem_ready), 32'd0);

    // Round-robin: both sides re-request each ready cycle (last grant = data)
    next_cycle();
    req_i(32'h1000);
    req_d(32'h2000, 32'h0, 4'h0, 1'b0);
    settle();
    check("rr_instr0", 32'(mem_in.mem_instr), 32'd1);
    for (int k = 1; k < 20; k++) begin
      next_cycle();
      mem_ack(32'(k));
      if ((k - 1) % 2 == 0) req_i(32'h1000 + 32'(k) * 32'd4);
      else                  req_d(32'h2000 + 32'(k) * 32'd4, 32'(k), 4'h3, 1'b0);
      settle();
      check("rr_iready", 32'(imem_out.mem_ready), 32'((k - 1) % 2 == 0));
      check("rr_dready", 32'(dmem_out.mem_ready), 32'((k - 1) % 2 == 1));
      check("rr_valid", 32'(mem_in.mem_valid), 32'd1);
      check("rr_instr", 32'(mem_in.mem_instr), 32'(k % 2 == 0));
    end
    next_cycle();
    mem_ack(32'd20);
    settle();
    check("rr_drain_dready", 32'(dmem_out.mem_ready), 32'd1);
    check("rr_drain_instr", 32'(mem_in.mem_instr), 32'd1);
    check("rr_drain_valid", 32'(mem_in.mem_valid), 32'd1);
    next_cycle();
    mem_ack(32'd21);
    settle();
    check("rr_last_iready", 32'(imem_out.mem_ready), 32'd1);
    check("rr_last_valid", 32'(mem_in.mem_valid), 32'd0);

    // Fixed priority instance: data wins every tie
    next_cycle();
    rst    = 1'b1;
    rst_fp = 1'b0;
    next_cycle();
    req_i(32'h0);
    req_d(32'h200, 32'h0, 4'h0, 1'b0);
    settle();
    check("fp_valid0", 32'(mem_in_fp.mem_valid), 32'd1);
    check("fp_instr0", 32'(mem_in_fp.mem_instr), 32'd0);
    check("fp_addr0", mem_in_fp.mem_addr, 32'h200);
    next_cycle();
    mem_ack(32'h1);
    req_d(32'h204, 32'h0, 4'h0, 1'b0);
    settle();
    check("fp_dready1", 32'(dmem_out_fp.mem_ready), 32'd1);
    check("fp_instr1", 32'(mem_in_fp.mem_instr), 32'd0);
    check("fp_addr1", mem_in_fp.mem_addr, 32'h204);
    next_cycle();
    mem_ack(32'h2);
    settle();
    check("fp_dready2", 32'(dmem_out_fp.mem_ready), 32'd1);
    check("fp_instr2", 32'(mem_in_fp.mem_instr), 32'd1);
    check("fp_valid2", 32'(mem_in_fp.mem_valid), 32'd1);
    next_cycle();
    mem_ack(32'h3);
    settle();
    check("fp_iready3", 32'(imem_out_fp.mem_ready), 32'd1);
    check("fp_irdata3", imem_out_fp.mem_rdata, 32'h3);
    check("fp_valid3", 32'(mem_in_fp.mem_valid), 32'd0);
    next_cycle();
    rst_fp = 1'b1;
    rst    = 1'b0;

    // Reset during BUSY_D abandons the grant; stray ready is ignored
    next_cycle();
    req_d(32'h300, 32'h11, 4'h1, 1'b0);
    settle();
    check("rb_issue", 32'(mem_in.mem_valid), 32'd1);
    next_cycle();
    rst = 1'b1;
    settle();
    check("rb_rst_valid", 32'(mem_in.mem_valid), 32'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();
    mem_ack(32'h5555);
    settle();
    check("rb_stray_dready", 32'(dmem_out.mem_ready), 32'd0);
    check("rb_stray_iready", 32'(imem_out.mem_ready), 32'd0);
    check("rb_stray_valid", 32'(mem_in.mem_valid), 32'd0);
    next_cycle();
    req_i(32'h80);
    settle();
    check("rb_next_valid", 32'(mem_in.mem_valid), 32'd1);
    check("rb_next_instr", 32'(mem_in.mem_instr), 32'd1);
    check("rb_next_addr", mem_in.mem_addr, 32'h80);
    next_cycle();
    mem_ack(32'h6666);
    settle();
    check("rb_next_iready", 32'(imem_out.mem_ready), 32'd1);
    check("rb_next_irdata", imem_out.mem_rdata, 32'h6666);

    next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
